// File: rtl/prbs16_checker.sv
// PRBS16 (x^16+x^14+x^13+x^11+1) receive checker: acquires lock on the incoming
// bit stream, then counts bit errors against a free-running reference and drops lock on bursts.
module prbs16_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic        lock_lost
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic prbs_pred(input logic [15:0] sr);
        return sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
    endfunction

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_sr, w_sr_nxt;
    logic [4:0]      r_fill_cnt, w_fill_nxt;
    logic [MW-1:0]   r_match_cnt, w_match_nxt;
    logic [WW-1:0]   r_win_cnt, w_win_cnt_nxt;
    logic [EW-1:0]   r_win_err, w_win_err_nxt;
    logic            r_locked, r_err_pulse, r_lock_lost;
    logic [15:0]     r_err_count;
    logic            w_pred, w_mismatch, w_err_det, w_loss;

    // Next-state and counter update for one valid bit; everything holds when bit_valid is low.
    always_comb begin
        w_pred        = prbs_pred(r_sr);
        w_mismatch    = bit_in ^ w_pred;
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_fill_nxt    = r_fill_cnt;
        w_match_nxt   = r_match_cnt;
        w_win_cnt_nxt = r_win_cnt;
        w_win_err_nxt = r_win_err;
        w_err_det     = 1'b0;
        w_loss        = 1'b0;
        if (bit_valid) begin
            case (r_state)
                SEARCH: begin
                    w_sr_nxt = {r_sr[14:0], bit_in};
                    if (r_fill_cnt == 5'd15) begin
                        w_state_nxt = VERIFY;
                        w_fill_nxt  = 5'd16;
                        w_match_nxt = '0;
                    end else begin
                        w_fill_nxt = r_fill_cnt + 5'd1;
                    end
                end
                VERIFY: begin
                    w_sr_nxt = {r_sr[14:0], bit_in};
                    // An all-zero history predicts 0 forever, so it never counts as evidence.
                    if (!w_mismatch && (r_sr != 16'h0000)) begin
                        w_match_nxt = r_match_cnt + MW'(1);
                        if (r_match_cnt == MW'(LOCK_COUNT - 1)) begin
                            w_state_nxt   = LOCKED;
                            w_win_cnt_nxt = '0;
                            w_win_err_nxt = '0;
                        end else begin
                            w_state_nxt = VERIFY;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    w_sr_nxt  = {r_sr[14:0], w_pred};
                    w_err_det = w_mismatch;
                    if (w_mismatch && (r_win_err == EW'(LOSS_THRESH - 1))) begin
                        w_loss        = 1'b1;
                        w_state_nxt   = SEARCH;
                        w_fill_nxt    = 5'd0;
                        w_match_nxt   = '0;
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else if (r_win_cnt == WW'(WIN_LEN - 1)) begin
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_win_cnt_nxt = r_win_cnt + WW'(1);
                        w_win_err_nxt = r_win_err + EW'(w_mismatch);
                    end
                end
                default: begin
                    w_state_nxt   = SEARCH;
                    w_fill_nxt    = 5'd0;
                    w_match_nxt   = '0;
                    w_win_cnt_nxt = '0;
                    w_win_err_nxt = '0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, history and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_sr        <= 16'h0000;
            r_fill_cnt  <= 5'd0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= 16'h0000;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_match_cnt <= w_match_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_win_err   <= w_win_err_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err_det;
            if (clr_cnt) begin
                r_err_count <= w_err_det ? 16'h0001 : 16'h0000;
            end else if (w_err_det && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'h0001;
            end else begin
                r_err_count <= r_err_count;
            end
            // A loss event wins over a simultaneous clear.
            if (w_loss) begin
                r_lock_lost <= 1'b1;
            end else if (clr_cnt) begin
                r_lock_lost <= 1'b0;
            end else begin
                r_lock_lost <= r_lock_lost;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: error events go through an expected-value queue
// checked by a monitor on err_pulse; status is checked at fixed points in the stimulus.
module tb_prbs16_checker;
    logic        clk;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        lock_lost;

    typedef struct {
        logic [15:0] cnt;
        logic        lk;
        logic        lost;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] gen;
    int          n_tests;
    int          n_fail;
    logic        flag;

    prbs16_checker #(.LOCK_COUNT(16), .WIN_LEN(64), .LOSS_THRESH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .lock_lost (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every err_pulse must match the next queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (err_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_err_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_err_count", {16'd0, err_count}, {16'd0, e.cnt});
                check("pulse_locked", {31'd0, locked}, {31'd0, e.lk});
                check("pulse_lock_lost", {31'd0, lock_lost}, {31'd0, e.lost});
            end
        end
    end

    task automatic send(input logic v, input logic inv, input logic clr);
        logic b;
        b = 1'b0;
        if (v) begin
            b   = gen[15] ^ gen[13] ^ gen[12] ^ gen[10];
            gen = {gen[14:0], b};
        end
        bit_in    = b ^ inv;
        bit_valid = v;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        clr_cnt   = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_raw(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic expect_err(input logic [15:0] cnt, input logic lk, input logic lost);
        exp_t e;
        e.cnt  = cnt;
        e.lk   = lk;
        e.lost = lost;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic lock_seq(input string name);
        for (int i = 1; i <= 32; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (i == 31) check({name, "_not_yet"}, {31'd0, locked}, 32'd0);
            if (i == 32) check({name, "_locked"}, {31'd0, locked}, 32'd1);
        end
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        gen       = 16'h1001;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clr_cnt   = 1'b0;
        reset     = 1'b1;
        #1;
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        check("rst_lock_lost", {31'd0, lock_lost}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Clean lock, then 1000 clean bits.
        lock_seq("clean");
        flag = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b1 || err_count !== 16'd0) flag = 1'b1;
        end
        check("clean_1000_stable", {31'd0, flag}, 32'd0);

        // Single inverted bit counts exactly once.
        expect_err(16'd1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        clean(100);
        check("single_err_count", {16'd0, err_count}, 32'd1);
        check("single_err_locked", {31'd0, locked}, 32'd1);

        // Clear, then 8 errors within one window force loss of lock.
        send(1'b1, 1'b0, 1'b1);
        check("clr_err_count", {16'd0, err_count}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            expect_err(16'(k), (k < 8), (k == 8));
            send(1'b1, 1'b1, 1'b0);
        end
        check("loss_locked", {31'd0, locked}, 32'd0);
        check("loss_lock_lost", {31'd0, lock_lost}, 32'd1);
        check("loss_err_count", {16'd0, err_count}, 32'd8);
        lock_seq("relock");
        check("relock_lost_sticky", {31'd0, lock_lost}, 32'd1);
        send(1'b1, 1'b0, 1'b1);
        check("clr_lock_lost", {31'd0, lock_lost}, 32'd0);
        check("clr2_err_count", {16'd0, err_count}, 32'd0);

        // Constant streams never lock.
        do_reset();
        flag = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send_raw(1'b0);
            if (locked !== 1'b0 || err_pulse !== 1'b0) flag = 1'b1;
        end
        check("const0_no_lock", {31'd0, flag}, 32'd0);
        do_reset();
        flag = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send_raw(1'b1);
            if (locked !== 1'b0 || err_pulse !== 1'b0) flag = 1'b1;
        end
        check("const1_no_lock", {31'd0, flag}, 32'd0);
        check("const1_err_count", {16'd0, err_count}, 32'd0);

        // Gapped stream locks after 32 valid bits regardless of gaps.
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            send(1'b1, 1'b0, 1'b0);
            if (k == 31) check("gap_not_yet", {31'd0, locked}, 32'd0);
            if (k == 32) check("gap_locked", {31'd0, locked}, 32'd1);
            for (int g = 0; g < (k % 3) + 1; g++) send(1'b0, 1'b0, 1'b0);
        end
        check("gap_hold_locked", {31'd0, locked}, 32'd1);
        expect_err(16'd1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        clean(70);
        expect_err(16'd2, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        clean(70);
        expect_err(16'd1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        check("clr_with_err_count", {16'd0, err_count}, 32'd1);

        // Four more errors to reach 5, then asynchronous reset while locked.
        for (int k = 2; k <= 5; k++) begin
            clean(70);
            expect_err(16'(k), 1'b1, 1'b0);
            send(1'b1, 1'b1, 1'b0);
        end
        clean(5);
        check("pre_reset_err_count", {16'd0, err_count}, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_locked", {31'd0, locked}, 32'd0);
        check("async_rst_err_count", {16'd0, err_count}, 32'd0);
        check("async_rst_lock_lost", {31'd0, lock_lost}, 32'd0);
        check("async_rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        lock_seq("post_rst");

        clean(4);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
